lock_sweep_ctrl: RTL and testbench

- Frequency-sweep scheduler for the quadrature lock-in chain: drives the 24-bit reference phase-increment word (Fword) into the PSD/NCO and consumes the lock-in amplitude stream (lock_tdata_valid/lock_tdata).
- Per sweep point: set Fword, wait for the low-pass FIR to settle, average 2^AVG_LOG2 amplitude samples, report the point, then step.
- Tracks peak amplitude and its Fword for resonance location of the photoacoustic cell.

---
 rtl/lock_sweep_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lock_sweep_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sweep_ctrl.sv
// lock_sweep_ctrl: frequency-sweep scheduler for the lock-in chain.
// Steps the reference Fword, waits for the FIR to settle, then averages
// 2^AVG_LOG2 amplitude samples per point and tracks the peak response.
// Ports:
//   sys_clk, sys_rst       clock, synchronous active-high reset
//   start, abort           one-cycle sweep start / abort strobes
//   f_start, f_step, n_pts sweep definition, latched on accepted start
//   lock_tdata_valid/_data amplitude sample stream (unsigned)
//   fword_o, busy          Fword to PSD, sweep in progress
//   pt_valid/idx/fword/amp per-point report (values hold between pulses)
//   peak_fword, peak_amp   largest reported amplitude of this sweep
//   done                   one-cycle pulse at normal completion
module lock_sweep_ctrl #(
    parameter int FWORD_W    = 24,
    parameter int AMP_W      = 24,
    parameter int SETTLE_CYC = 4096,
    parameter int AVG_LOG2   = 4,
    parameter int NPTS_W     = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FWORD_W-1:0] f_start,
    input  logic [FWORD_W-1:0] f_step,
    input  logic [NPTS_W-1:0]  n_pts,
    input  logic               lock_tdata_valid,
    input  logic [AMP_W-1:0]   lock_tdata,
    output logic [FWORD_W-1:0] fword_o,
    output logic               busy,
    output logic               pt_valid,
    output logic [NPTS_W-1:0]  pt_idx,
    output logic [FWORD_W-1:0] pt_fword,
    output logic [AMP_W-1:0]   pt_amp,
    output logic [FWORD_W-1:0] peak_fword,
    output logic [AMP_W-1:0]   peak_amp,
    output logic               done
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int AW = AMP_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE, SETTLE, ACCUM, REPORT, DONE
    } state_t;

    state_t state, state_nx;

    logic [SW-1:0]      settle_cnt;
    logic [CW-1:0]      smp_cnt;
    logic [AW-1:0]      acc;
    logic [FWORD_W-1:0] step_q;
    logic [NPTS_W-1:0]  npts_q;
    logic [NPTS_W-1:0]  idx;
    logic [AMP_W-1:0]   avg;
    logic [AMP_W-1:0]   pt_amp_q;
    logic [FWORD_W-1:0] pt_fword_q;
    logic [NPTS_W-1:0]  pt_idx_q;
    logic               settle_end;
    logic               accum_end;
    logic               last_pt;
    logic               peak_upd;

    assign avg        = acc[AW-1:AVG_LOG2];
    assign settle_end = (settle_cnt == SW'(SETTLE_CYC - 1));
    assign accum_end  = lock_tdata_valid &&
                        (smp_cnt == CW'((1 << AVG_LOG2) - 1));
    assign last_pt    = (idx == npts_q - NPTS_W'(1));
    // First point of a sweep always claims the peak, even at amplitude 0.
    assign peak_upd   = (idx == '0) || (avg > peak_amp);

    assign busy     = (state != IDLE);
    // Report fields present the live average during the pulse, then hold.
    assign pt_amp   = pt_valid ? avg     : pt_amp_q;
    assign pt_fword = pt_valid ? fword_o : pt_fword_q;
    assign pt_idx   = pt_valid ? idx     : pt_idx_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pt_valid = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (n_pts == '0) ? DONE : SETTLE;
            end
            SETTLE: begin
                if (settle_end) state_nx = ACCUM;
            end
            ACCUM: begin
                if (accum_end) state_nx = REPORT;
            end
            REPORT: begin
                pt_valid = 1'b1;
                state_nx = last_pt ? DONE : SETTLE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort and reset suppress any pulse of the current cycle.
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            pt_valid = 1'b0;
            done     = 1'b0;
        end
        if (sys_rst) begin
            pt_valid = 1'b0;
            done     = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fword_o    <= '0;
            settle_cnt <= '0;
            smp_cnt    <= '0;
            acc        <= '0;
            step_q     <= '0;
            npts_q     <= '0;
            idx        <= '0;
            pt_amp_q   <= '0;
            pt_fword_q <= '0;
            pt_idx_q   <= '0;
            peak_fword <= '0;
            peak_amp   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        step_q     <= f_step;
                        npts_q     <= n_pts;
                        idx        <= '0;
                        peak_amp   <= '0;
                        peak_fword <= '0;
                        if (n_pts != '0) begin
                            fword_o    <= f_start;
                            settle_cnt <= '0;
                        end
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    acc        <= '0;
                    smp_cnt    <= '0;
                end
                ACCUM: begin
                    if (lock_tdata_valid) begin
                        acc     <= acc + AW'(lock_tdata);
                        smp_cnt <= smp_cnt + CW'(1);
                    end
                end
                REPORT: begin
                    if (pt_valid) begin
                        pt_amp_q   <= avg;
                        pt_fword_q <= fword_o;
                        pt_idx_q   <= idx;
                        if (peak_upd) begin
                            peak_amp   <= avg;
                            peak_fword <= fword_o;
                        end
                        if (!last_pt) begin
                            idx        <= idx + NPTS_W'(1);
                            fword_o    <= fword_o + step_q;
                            settle_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lock_sweep_ctrl.sv
// tb_lock_sweep_ctrl: directed bench for lock_sweep_ctrl
// (SETTLE_CYC=8, AVG_LOG2=2).
module tb_lock_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic        abort;
    logic [23:0] f_start;
    logic [23:0] f_step;
    logic [15:0] n_pts;
    logic        lock_tdata_valid;
    logic [23:0] lock_tdata;
    logic [23:0] fword_o;
    logic        busy;
    logic        pt_valid;
    logic [15:0] pt_idx;
    logic [23:0] pt_fword;
    logic [23:0] pt_amp;
    logic [23:0] peak_fword;
    logic [23:0] peak_amp;
    logic        done;

    lock_sweep_ctrl #(
        .FWORD_W(24), .AMP_W(24), .SETTLE_CYC(8),
        .AVG_LOG2(2), .NPTS_W(16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .start(start), .abort(abort),
        .f_start(f_start), .f_step(f_step), .n_pts(n_pts),
        .lock_tdata_valid(lock_tdata_valid), .lock_tdata(lock_tdata),
        .fword_o(fword_o), .busy(busy),
        .pt_valid(pt_valid), .pt_idx(pt_idx),
        .pt_fword(pt_fword), .pt_amp(pt_amp),
        .peak_fword(peak_fword), .peak_amp(peak_amp),
        .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    // event monitor
    int          cyc = 0;
    int          ev_cyc = 0;
    int          st_cyc = 0;
    int          n_pv = 0;
    int          n_done = 0;
    int          n_busy = 0;
    logic [23:0] rec_amp [64];
    logic [23:0] rec_fw  [64];
    logic [15:0] rec_idx [64];
    int          rec_cyc [64];

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (pt_valid) begin
            rec_amp[n_pv[5:0]] <= pt_amp;
            rec_fw[n_pv[5:0]]  <= pt_fword;
            rec_idx[n_pv[5:0]] <= pt_idx;
            rec_cyc[n_pv[5:0]] <= cyc + 1;
            n_pv   <= n_pv + 1;
            ev_cyc <= cyc + 1;
        end
        if (start && !busy && !sys_rst) begin
            st_cyc <= cyc + 1;
            ev_cyc <= cyc + 1;
        end
        if (done) n_done <= n_done + 1;
        if (busy) n_busy <= n_busy + 1;
    end

    // amplitude source
    logic [23:0] amp_tab [4];
    int          base = 0;
    int          period = 1;
    bit          jit_en = 0;
    bit          garb_en = 0;
    int          vcnt = 0;

    always @(negedge sys_clk) begin
        logic [1:0] ki;
        int         j;
        ki = 2'(n_pv - base);
        if (garb_en && (cyc - ev_cyc) < 8) begin
            lock_tdata_valid = 1'b1;
            lock_tdata       = 24'hFFFFFF;
        end else if ((cyc % period) == 0) begin
            case (vcnt % 4)
                0:       j = -1;
                2:       j = 1;
                default: j = 0;
            endcase
            if (!jit_en) j = 0;
            lock_tdata_valid = 1'b1;
            lock_tdata       = 24'(int'(amp_tab[ki]) + j);
            vcnt             = vcnt + 1;
        end else begin
            lock_tdata_valid = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    task automatic do_start(input logic [23:0] fs, input logic [23:0] fp,
                            input logic [15:0] np);
        base    = n_pv;
        f_start = fs;
        f_step  = fp;
        n_pts   = np;
        start   = 1'b1;
        @(negedge sys_clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = n_done;
        for (int i = 0; i < budget && n_done == d0; i++)
            @(negedge sys_clk);
        chk("done_timeout", 32'(n_done - d0), 32'd1);
    endtask

    task automatic wait_pts(input int target, input int budget);
        for (int i = 0; i < budget && n_pv < target; i++)
            @(negedge sys_clk);
        chk("pt_timeout", 32'(n_pv), 32'(target));
    endtask

    initial begin
        int d0;
        int p0;
        int b0;
        sys_rst = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        f_start = '0;
        f_step  = '0;
        n_pts   = '0;
        for (int i = 0; i < 4; i++) amp_tab[i] = 24'd100;
        tick(3);
        sys_rst = 1'b0;
        tick(1);
        chk("rst_fword", 32'(fword_o), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_peak", 32'(peak_amp), 32'h0);
        chk("rst_ptamp", 32'(pt_amp), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // constant amplitude 100, valid every cycle
        do_start(24'h001000, 24'h000100, 16'd3);
        chk("s1_fword0", 32'(fword_o), 32'h001000);
        chk("s1_busy", 32'(busy), 32'h1);
        wait_done(200);
        for (int i = 0; i < 3; i++) begin
            chk("s1_amp", 32'(rec_amp[base + i]), 32'd100);
            chk("s1_idx", 32'(rec_idx[base + i]), 32'(i));
            chk("s1_fw", 32'(rec_fw[base + i]), 32'(24'h001000 + 24'h100 * i));
        end
        chk("s1_lat", 32'(rec_cyc[base] - st_cyc), 32'd13);
        chk("s1_npts", 32'(n_pv - base), 32'd3);
        chk("s1_peakfw", 32'(peak_fword), 32'h001000);
        chk("s1_peakamp", 32'(peak_amp), 32'd100);
        chk("s1_fwhold", 32'(fword_o), 32'h001200);
        chk("s1_idle", 32'(busy), 32'h0);

        // 10/50/30 with jitter, valid every 3rd cycle, junk during settle
        period  = 3;
        jit_en  = 1;
        garb_en = 1;
        amp_tab[0] = 24'd10;
        amp_tab[1] = 24'd50;
        amp_tab[2] = 24'd30;
        do_start(24'h002000, 24'h000300, 16'd3);
        wait_done(400);
        chk("s2_amp0", 32'(rec_amp[base]), 32'd10);
        chk("s2_amp1", 32'(rec_amp[base + 1]), 32'd50);
        chk("s2_amp2", 32'(rec_amp[base + 2]), 32'd30);
        chk("s2_peakamp", 32'(peak_amp), 32'd50);
        chk("s2_peakfw", 32'(peak_fword), 32'h002300);

        // tie keeps the first point
        amp_tab[0] = 24'd40;
        amp_tab[1] = 24'd40;
        do_start(24'h003000, 24'h000010, 16'd2);
        wait_done(300);
        chk("s3_peakamp", 32'(peak_amp), 32'd40);
        chk("s3_peakfw", 32'(peak_fword), 32'h003000);

        // Fword wraps modulo 2^24
        amp_tab[0] = 24'd7;
        amp_tab[1] = 24'd7;
        do_start(24'hFFFF80, 24'h000100, 16'd2);
        wait_done(300);
        chk("s4_fw1", 32'(rec_fw[base + 1]), 32'h000080);
        chk("s4_fwhold", 32'(fword_o), 32'h000080);
        chk("s4_peakfw", 32'(peak_fword), 32'hFFFF80);

        // zero points; start during busy ignored
        d0 = n_done;
        p0 = n_pv;
        b0 = n_busy;
        f_start = 24'h00AAAA;
        n_pts   = 16'd0;
        start   = 1'b1;
        @(negedge sys_clk);
        chk("s5_done", 32'(done), 32'h1);
        n_pts = 16'd5;
        @(negedge sys_clk);
        start = 1'b0;
        chk("s5_busy", 32'(busy), 32'h0);
        tick(20);
        chk("s5_busycyc", 32'(n_busy - b0), 32'd1);
        chk("s5_ndone", 32'(n_done - d0), 32'd1);
        chk("s5_nopt", 32'(n_pv - p0), 32'd0);
        chk("s5_peak", 32'(peak_amp), 32'h0);
        chk("s5_peakfw", 32'(peak_fword), 32'h0);
        chk("s5_pthold", 32'(pt_amp), 32'd7);

        // abort in ACCUM of point 1
        amp_tab[0] = 24'd20;
        amp_tab[1] = 24'd60;
        amp_tab[2] = 24'd60;
        d0 = n_done;
        do_start(24'h004000, 24'h000100, 16'd3);
        wait_pts(base + 1, 200);
        tick(10);
        p0 = n_pv;
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        chk("s6_busy", 32'(busy), 32'h0);
        chk("s6_fword", 32'(fword_o), 32'h004100);
        chk("s6_peakamp", 32'(peak_amp), 32'd20);
        chk("s6_peakfw", 32'(peak_fword), 32'h004000);
        tick(30);
        chk("s6_nopt", 32'(n_pv - p0), 32'd0);
        chk("s6_nodone", 32'(n_done - d0), 32'd0);

        // reset mid-sweep
        do_start(24'h005000, 24'h000100, 16'd3);
        tick(5);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("s7_busy", 32'(busy), 32'h0);
        chk("s7_fword", 32'(fword_o), 32'h0);
        chk("s7_peakamp", 32'(peak_amp), 32'h0);
        chk("s7_peakfw", 32'(peak_fword), 32'h0);
        chk("s7_ptamp", 32'(pt_amp), 32'h0);
        chk("s7_ptfw", 32'(pt_fword), 32'h0);
        tick(40);
        chk("s7_idle", 32'(busy), 32'h0);
        chk("s7_nodone", 32'(n_done - d0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
